// File: rtl/dds_pwm_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pwm_dac_pkg
//  Description : Shared definitions for the DDS PWM output stage: default
//                sample width, FSM state encoding and triangle-counter
//                direction encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pwm_dac_pkg;

    localparam int c_DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/dds_pwm_dac_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : dds_prescaler
//  Description : Divides clk by PRESCALE and emits a one-clk tick. The tick is
//                high while the divider sits at 0, so the first cycle after a
//                clear is always a tick. PRESCALE=1 gives a permanent tick.
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                clear - synchronous clear, holds the divider at 0
//                tick  - count-advance strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                c_CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(PRESCALE - 1);
    localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (clear || (r_div == c_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_ONE;
        end
    end

    assign tick = (r_div == '0);

endmodule
`default_nettype wire

// File: rtl/dds_pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pwm_dac
//  Description : Converts an unsigned sample stream into a 1-bit PWM drive.
//                One-entry shadow buffer with valid/ready handshake; the duty
//                register is reloaded only at PWM period boundaries.
//                Build option DDS_PWM_CENTER_EN selects a triangle
//                (centre-aligned) counter instead of the default sawtooth.
//  Ports       : clk, reset (async, active-high)
//                enable                    - 1 = RUN, 0 = IDLE
//                sample_in/valid/ready     - sample handshake
//                pwm_out                   - registered PWM output
//                period_start              - pulse in the duty-load cycle
//                underrun / underrun_clr   - sticky missing-sample flag
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_pwm_dac
    import dds_pwm_dac_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEF,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam logic [DATA_W-1:0] c_ONE = DATA_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_duty;
    logic [DATA_W-1:0] w_duty_nxt;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] w_shadow_nxt;
    logic              r_full;
    logic              w_full_nxt;
    logic              r_pwm;
    logic              r_underrun;
    logic              w_tick;
    logic              w_stay_run;
    logic              w_boundary;
    logic              w_accept;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counting only continues while RUN persists into the next cycle; a
    // dropped enable clears counter, prescaler and output on the same edge.
    assign w_stay_run = (r_state == ST_RUN) && enable;

    dds_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (!w_stay_run),
        .tick  (w_tick)
    );

    assign w_boundary = w_stay_run && w_tick && (r_cnt == '0);
    assign w_accept   = sample_valid && !r_full;

    // ------------------------------------------------ shadow / duty update
    always_comb begin
        w_duty_nxt   = r_duty;
        w_shadow_nxt = r_shadow;
        w_full_nxt   = r_full;
        if (!w_stay_run) begin
            w_duty_nxt = '0;
        end else if (w_boundary) begin
            if (r_full) begin
                w_duty_nxt = r_shadow;
            end else if (w_accept) begin
                w_duty_nxt = sample_in;   // bypass: shadow stays empty
            end
        end
        if (w_boundary && r_full) begin
            w_full_nxt = 1'b0;
        end else if (w_accept && !w_boundary) begin
            w_full_nxt   = 1'b1;
            w_shadow_nxt = sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty     <= '0;
            r_shadow   <= '0;
            r_full     <= 1'b0;
            r_pwm      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_duty   <= w_duty_nxt;
            r_shadow <= w_shadow_nxt;
            r_full   <= w_full_nxt;
            // Compare against the duty being loaded so the boundary count
            // already uses the new period's duty.
            r_pwm    <= w_stay_run && (r_cnt < w_duty_nxt);
            if (w_boundary && !r_full && !w_accept) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ counter
`ifdef DDS_PWM_CENTER_EN
    localparam logic [DATA_W-1:0] c_MAX = {DATA_W{1'b1}};
    dir_t r_dir;

    // Triangle 0 -> MAX -> 1 -> 0: count 0 appears once per period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else if (!w_stay_run) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else if (w_tick) begin
            if (r_dir == DIR_UP) begin
                if (r_cnt == c_MAX) begin
                    r_dir <= DIR_DOWN;
                    r_cnt <= r_cnt - c_ONE;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                if (r_cnt == c_ONE) begin
                    r_dir <= DIR_UP;
                end
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_stay_run) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end
`endif

    assign sample_ready = !r_full;
    assign pwm_out      = r_pwm;
    assign period_start = w_boundary;
    assign underrun     = r_underrun;

endmodule
`default_nettype wire
